// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle sequencer that fetches operands, drives the ALU, commits flags and writes back
module alu_exec_ctrl #(
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Instr_Valid,
  output logic          Instr_Ready,
  input  logic [3:0]    Instr_Mode,
  input  logic [AW-1:0] Instr_Rd,
  input  logic [AW-1:0] Instr_Rs,
  input  logic [7:0]    Instr_Imm,
  input  logic          Instr_UseImm,
  input  logic          Instr_NoWB,
  output logic [AW-1:0] RF_RAddr,
  input  logic [7:0]    RF_RData,
  output logic          RF_WE,
  output logic [AW-1:0] RF_WAddr,
  output logic [7:0]    RF_WData,
  output logic [7:0]    Operand1,
  output logic [7:0]    Operand2,
  output logic [3:0]    Mode,
  output logic          E,
  input  logic [7:0]    Out_ALU,
  input  logic [3:0]    ALU_Flags,
  output logic [3:0]    CFlags,
  output logic          Busy,
  output logic          Done
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, EXEC, WB} state_t;
  state_t        state_q, state_d;
  logic [3:0]    mode_q, mode_d, cflags_q, cflags_d;
  logic [AW-1:0] rd_q, rd_d, rs_q, rs_d;
  logic [7:0]    imm_q, imm_d, op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic          use_imm_q, use_imm_d, no_wb_q, no_wb_d, carry_mode;
  assign carry_mode  = mode_q inside {4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b1001, 4'b1111};
  assign Instr_Ready = state_q == IDLE;
  assign Busy        = state_q != IDLE;
  assign E           = state_q == EXEC;
  assign Done        = state_q == WB;
  assign RF_WE       = Done && !no_wb_q;
  assign RF_WAddr    = Done ? rd_q : '0;
  assign RF_WData    = Done ? res_q : '0;
  assign RF_RAddr    = state_q == RD1 ? rd_q : state_q == RD2 ? rs_q : '0;
  assign Operand1    = op1_q;
  assign Operand2    = op2_q;
  assign Mode        = mode_q;
  assign CFlags      = cflags_q;
  // next-state and datapath capture; carry is only committed by arithmetic modes
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    no_wb_d   = no_wb_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    res_d     = res_q;
    cflags_d  = cflags_q;
    case (state_q)
      IDLE: if (Instr_Valid) begin
        mode_d    = Instr_Mode;
        rd_d      = Instr_Rd;
        rs_d      = Instr_Rs;
        imm_d     = Instr_Imm;
        use_imm_d = Instr_UseImm;
        no_wb_d   = Instr_NoWB;
        state_d   = RD1;
      end
      RD1: begin
        op1_d   = RF_RData;
        op2_d   = use_imm_q ? imm_q : op2_q;
        state_d = use_imm_q ? EXEC : RD2;
      end
      RD2: begin
        op2_d   = RF_RData;
        state_d = EXEC;
      end
      EXEC: begin
        res_d    = Out_ALU;
        cflags_d = {ALU_Flags[3], carry_mode ? ALU_Flags[2] : cflags_q[2], ALU_Flags[1:0]};
        state_d  = WB;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any in-flight instruction
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      no_wb_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      res_q     <= '0;
      cflags_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      no_wb_q   <= no_wb_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      res_q     <= res_d;
      cflags_q  <= cflags_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed vectors against a register-file and ALU environment
module tb_alu_exec_ctrl;
  logic       Clk = 1'b0, Rst_n = 1'b0;
  logic       Instr_Valid = 1'b0, Instr_Ready;
  logic [3:0] Instr_Mode = '0;
  logic [2:0] Instr_Rd = '0, Instr_Rs = '0;
  logic [7:0] Instr_Imm = '0;
  logic       Instr_UseImm = 1'b0, Instr_NoWB = 1'b0;
  logic [2:0] RF_RAddr, RF_WAddr;
  logic [7:0] RF_RData, RF_WData, Operand1, Operand2, Out_ALU;
  logic       RF_WE, E, Busy, Done;
  logic [3:0] Mode, ALU_Flags, CFlags;
  logic [7:0] rf [8];
  logic       load_en = 1'b0;
  logic [2:0] load_a = '0;
  logic [7:0] load_d = '0;
  int         we_count = 0, we_before;
  int         n_vec = 0, n_bad = 0;
  int         e_cyc, done_cyc, d1, d2;
  logic [2:0] ra1, ra2, wa, ra6;
  logic [7:0] wd, op1x, op2x, wd1, wd2, op1b;
  logic [3:0] modex, fl5;
  logic       wex, rdy5;
  logic [8:0] sum;
  logic [7:0] alu_r;
  logic       alu_c, alu_o;

  alu_exec_ctrl #(.AW(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .Instr_Mode(Instr_Mode), .Instr_Rd(Instr_Rd), .Instr_Rs(Instr_Rs), .Instr_Imm(Instr_Imm),
    .Instr_UseImm(Instr_UseImm), .Instr_NoWB(Instr_NoWB), .RF_RAddr(RF_RAddr), .RF_RData(RF_RData),
    .RF_WE(RF_WE), .RF_WAddr(RF_WAddr), .RF_WData(RF_WData), .Operand1(Operand1), .Operand2(Operand2),
    .Mode(Mode), .E(E), .Out_ALU(Out_ALU), .ALU_Flags(ALU_Flags), .CFlags(CFlags), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  assign RF_RData = rf[RF_RAddr];

  // register file: DUT write port, plus a preload path used only while the DUT is idle
  always @(posedge Clk) begin
    if (RF_WE) begin
      rf[RF_WAddr] <= RF_WData;
      we_count     <= we_count + 1;
    end else if (load_en) rf[load_a] <= load_d;
  end

  // ALU: add, sub (carry = no borrow), and, xor; logic ops report carry 0
  always_comb begin
    sum   = {1'b0, Operand1} + {1'b0, Operand2};
    alu_r = Operand1;
    alu_c = 1'b0;
    alu_o = 1'b0;
    case (Mode)
      4'd0: begin
        alu_r = sum[7:0];
        alu_c = sum[8];
        alu_o = (Operand1[7] == Operand2[7]) && (alu_r[7] != Operand1[7]);
      end
      4'd1: begin
        alu_r = Operand1 - Operand2;
        alu_c = Operand1 >= Operand2;
        alu_o = (Operand1[7] != Operand2[7]) && (alu_r[7] != Operand1[7]);
      end
      4'd2: alu_r = Operand1 & Operand2;
      4'd6: alu_r = Operand1 ^ Operand2;
      default: alu_r = Operand1;
    endcase
  end
  assign Out_ALU   = alu_r;
  assign ALU_Flags = {alu_r == 8'h00, alu_c, alu_r[7], alu_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    load_a  = a;
    load_d  = d;
    load_en = 1'b1;
    @(negedge Clk);
    load_en = 1'b0;
  endtask

  task automatic run(input logic [3:0] m, input logic [2:0] d, input logic [2:0] s,
                     input logic [7:0] im, input logic ui, input logic nw);
    Instr_Mode   = m;
    Instr_Rd     = d;
    Instr_Rs     = s;
    Instr_Imm    = im;
    Instr_UseImm = ui;
    Instr_NoWB   = nw;
    Instr_Valid  = 1'b1;
    @(negedge Clk);
    Instr_Valid = 1'b0;
    e_cyc    = 0;
    done_cyc = 0;
    for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
      if (c == 1) ra1 = RF_RAddr;
      if (c == 2) ra2 = RF_RAddr;
      if (E) begin
        e_cyc = c;
        op1x  = Operand1;
        op2x  = Operand2;
        modex = Mode;
      end
      if (Done) begin
        done_cyc = c;
        wex      = RF_WE;
        wa       = RF_WAddr;
        wd       = RF_WData;
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_ready", Instr_Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_e", E, 0);
    chk("rst_we", RF_WE, 0);
    chk("rst_raddr", RF_RAddr, 0);
    chk("rst_waddr", RF_WAddr, 0);
    chk("rst_wdata", RF_WData, 0);
    chk("rst_ops", {Operand1, Operand2, Mode}, 0);
    chk("rst_cflags", CFlags, 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    load(3'd1, 8'h7F);
    load(3'd2, 8'h01);
    run(4'd0, 3'd1, 3'd2, 8'h00, 1'b0, 1'b0);
    chk("add_done_cyc", done_cyc, 4);
    chk("add_e_cyc", e_cyc, 3);
    chk("add_raddr1", ra1, 1);
    chk("add_raddr2", ra2, 2);
    chk("add_ops", {op1x, op2x, modex}, {8'h7F, 8'h01, 4'd0});
    chk("add_wb", {wex, wa, wd}, {1'b1, 3'd1, 8'h80});
    chk("add_rf1", rf[1], 8'h80);
    chk("add_cflags", CFlags, 4'b0011);
    chk("add_ready", Instr_Ready, 1);
    load(3'd3, 8'h05);
    run(4'd1, 3'd3, 3'd0, 8'h05, 1'b1, 1'b0);
    chk("subi_done_cyc", done_cyc, 3);
    chk("subi_e_cyc", e_cyc, 2);
    chk("subi_op2", op2x, 8'h05);
    chk("subi_wb", {wex, wa, wd}, {1'b1, 3'd3, 8'h00});
    chk("subi_rf3", rf[3], 8'h00);
    chk("subi_cflags", CFlags, 4'b1100);
    load(3'd4, 8'hAA);
    load(3'd5, 8'hAA);
    we_before = we_count;
    run(4'd6, 3'd4, 3'd5, 8'h00, 1'b0, 1'b1);
    chk("cmp_done_cyc", done_cyc, 4);
    chk("cmp_we", wex, 0);
    chk("cmp_we_count", we_count, we_before);
    chk("cmp_rf4", rf[4], 8'hAA);
    chk("cmp_cflags", CFlags, 4'b1100);
    load(3'd1, 8'h90);
    load(3'd2, 8'h80);
    Instr_Mode   = 4'd0;
    Instr_Rd     = 3'd1;
    Instr_Rs     = 3'd2;
    Instr_UseImm = 1'b0;
    Instr_NoWB   = 1'b0;
    Instr_Valid  = 1'b1;
    @(negedge Clk);
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (Done && d1 == 0) begin
        d1  = c;
        wd1 = RF_WData;
      end else if (Done) begin
        d2  = c;
        wd2 = RF_WData;
      end
      if (c == 5) begin
        rdy5 = Instr_Ready;
        fl5  = CFlags;
      end
      if (c == 6) ra6 = RF_RAddr;
      if (E && c > 5) op1b = Operand1;
      if (c == 1) begin
        Instr_Mode  = 4'd2;
        Instr_Rs    = 3'd1;
        Instr_Valid = 1'b0;
      end
      if (c == 2) Instr_Valid = 1'b1;
      if (c == 3) Instr_Valid = 1'b0;
      if (c == 4) Instr_Valid = 1'b1;
      if (c == 6) Instr_Valid = 1'b0;
      @(negedge Clk);
    end
    chk("b2b_done1", d1, 4);
    chk("b2b_wdata1", wd1, 8'h10);
    chk("b2b_ready5", rdy5, 1);
    chk("b2b_flags5", fl5, 4'b0101);
    chk("b2b_raddr6", ra6, 1);
    chk("b2b_raw_op1", op1b, 8'h10);
    chk("b2b_done2", d2, 9);
    chk("b2b_wdata2", wd2, 8'h10);
    chk("b2b_rf1", rf[1], 8'h10);
    chk("b2b_cflags", CFlags, 4'b0100);
    load(3'd6, 8'h01);
    load(3'd7, 8'h02);
    we_before    = we_count;
    Instr_Mode   = 4'd0;
    Instr_Rd     = 3'd6;
    Instr_Rs     = 3'd7;
    Instr_Valid  = 1'b1;
    @(negedge Clk);
    Instr_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rmid_in_exec", E, 1);
    Rst_n = 1'b0;
    #1;
    chk("rmid_busy", Busy, 0);
    chk("rmid_ready", Instr_Ready, 1);
    chk("rmid_cflags", CFlags, 0);
    chk("rmid_e_we", {E, RF_WE}, 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("rmid_post_ready", Instr_Ready, 1);
    chk("rmid_post_busy", Busy, 0);
    chk("rmid_rf6", rf[6], 8'h01);
    chk("rmid_we_count", we_count, we_before);
    chk("rmid_post_cflags", CFlags, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execute sequencer that owns the 8-bit ALU in the microcontroller core. It accepts one decoded ALU instruction at a time over a valid/ready handshake, reads the operands from the register file through a single read port, drives the ALU's `Operand1`/`Operand2`/`Mode`/`E`, latches the result and condition flags, and writes the result back. It sits between the instruction decoder and the ALU/register-file pair.

## Interface
- `AW`, default 3: register-file address width (8 registers).
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Instr_Valid`  in  1  decoder presents an instruction.
- `Instr_Ready`  out  1  controller can accept an instruction (IDLE).
- `Instr_Mode`  in  4  ALU mode code.
- `Instr_Rd`  in  AW  destination and Operand1 register.
- `Instr_Rs`  in  AW  Operand2 register.
- `Instr_Imm`  in  8  immediate Operand2.
- `Instr_UseImm`  in  1  1: Operand2 = `Instr_Imm`; 0: Operand2 = R[`Instr_Rs`].
- `Instr_NoWB`  in  1  1: update flags only (compare/test), no register write.
- `RF_RAddr`  out  AW  register-file read address. Read is combinational: `RF_RData` is valid in the same cycle.
- `RF_RData`  in  8  register-file read data.
- `RF_WE`  out  1  register-file write enable.
- `RF_WAddr`  out  AW  write address.
- `RF_WData`  out  8  write data.
- `Operand1`, `Operand2`  out  8  ALU operands.
- `Mode`  out  4  ALU mode.
- `E`  out  1  ALU enable.
- `Out_ALU`  in  8  ALU result (combinational).
- `ALU_Flags`  in  4  ALU flags `{z,c,s,o}`.
- `CFlags`  out  4  committed flag register `{Z,C,S,O}`.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse in the WB cycle.

## Operation
- FSM states: IDLE, RD1, RD2, EXEC, WB. Reset state is IDLE.
- **IDLE**
  - `Instr_Ready`=1.
  - On `Instr_Valid`&&`Instr_Ready` at an edge: latch Mode, Rd, Rs, Imm, UseImm and NoWB, then go to RD1.
  - Inputs are ignored while the FSM is not in IDLE.
- **RD1**
  - `RF_RAddr`=Rd.
  - Capture `RF_RData` into the Operand1 register.
  - If UseImm: load the Operand2 register from Imm and go to EXEC. Otherwise go to RD2.
- **RD2**
  - `RF_RAddr`=Rs.
  - Capture `RF_RData` into the Operand2 register, then go to EXEC.
- **EXEC**
  - `E`=1. `Operand1`, `Operand2` and `Mode` are stable from the registers.
  - Capture `Out_ALU` into the result register, then go to WB.
  - Update `CFlags` from `ALU_Flags` as follows:
    - Z, S and O are always taken.
    - C is taken only for the arithmetic modes 0000, 0001, 0111, 1000, 1001 and 1111.
    - For all other modes, C keeps its previous value.
- **WB**
  - `Done`=1.
  - `RF_WE`=!NoWB, `RF_WAddr`=Rd, `RF_WData`=result.
  - Go to IDLE.
- `RF_RAddr` is 0 outside RD1/RD2. `RF_WE`, `E` and `Done` are 0 outside their states. `Operand1`/`Operand2`/`Mode` hold their last values.
- Rd==Rs is legal; both reads return the same register.
- **Reset mid-operation:** asserting `Rst_n`=0 in any state immediately forces IDLE. No write occurs, and a pending writeback is discarded.

## Timing
- Reset values:
  - `Instr_Ready`=1 (IDLE).
  - `Busy`, `Done`, `E` and `RF_WE` = 0.
  - `RF_RAddr`, `RF_WAddr` and `RF_WData` = 0.
  - `Operand1`, `Operand2`, `Mode` and `CFlags` = 0.
- Let edge 0 be the accept edge. Register-register sequence:
  - RD1 during cycle 1, RD2 during cycle 2.
  - EXEC during cycle 3, with the flags committed at edge 4.
  - WB during cycle 4; the register write takes effect at edge 5.
  - IDLE with `Instr_Ready`=1 during cycle 5.
  - Total: 5 cycles per instruction.
- Immediate instructions skip RD2: 4 cycles per instruction, with `Done` in cycle 3.
- Back-to-back: if `Instr_Valid` is held, the next accept happens at the first IDLE edge.
  - The next instruction's RD1 therefore falls after the previous write edge.
  - Read-after-write to the same register returns the new value; no forwarding is required.
- `CFlags` changes only at the EXEC→WB edge.

## Test plan
- **Reset mid-instruction.** Assert `Rst_n`=0 during EXEC.
  - Required: immediately IDLE, `CFlags`=0, `Busy`=0, no `RF_WE` pulse.
  - After release: `Instr_Ready`=1.
- **ADD, register-register.** R1=0x7F, R2=0x01, Mode 0000, Rd=1, Rs=2.
  - Required: `Done` in cycle 4.
  - Write R1=0x80 at edge 5.
  - `CFlags` = {Z0,C0,S1,O1}.
- **SUB with immediate.** R3=0x05, Imm=0x05, UseImm=1, Mode 0001.
  - Required: 4-cycle latency, no RD2 state, R3=0x00.
  - Z=1, and C=1 as reported by the ALU.
- **Compare does not write.** NoWB=1 with Mode 0110 (XOR), R4=0xAA, R5=0xAA.
  - Required: `RF_WE` stays 0, Z=1.
  - C is unchanged from the previous instruction (preload C=1 and check it is still 1).
- **Back-to-back RAW hazard.** Hold `Instr_Valid` for ADD R1+=R2, then AND R1&=R1.
  - Required: the second instruction is accepted in the IDLE cycle (cycle 5).
  - Its RD1 reads the updated R1.
  - `Instr_Valid` changes while `Busy`=1 are ignored.
